// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle between the bridge's m1 master port and the register responder.
// The master modport drives requests; the slave modport drives ready/response signals.
interface axil_reg_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr;
  logic                    s0_axi_awvalid;
  logic                    s0_axi_awready;
  logic [DATA_WIDTH-1:0]   s0_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb;
  logic                    s0_axi_wvalid;
  logic                    s0_axi_wready;
  logic                    s0_axi_bresp;
  logic                    s0_axi_bvalid;
  logic                    s0_axi_bready;
  logic [ADDR_WIDTH-1:0]   s0_axi_araddr;
  logic                    s0_axi_arvalid;
  logic                    s0_axi_arready;
  logic [DATA_WIDTH-1:0]   s0_axi_rdata;
  logic                    s0_axi_rresp;
  logic                    s0_axi_rvalid;
  logic                    s0_axi_rready;

  modport master (
    output s0_axi_awaddr, s0_axi_awvalid, s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid,
           s0_axi_bready, s0_axi_araddr, s0_axi_arvalid, s0_axi_rready,
    input  s0_axi_awready, s0_axi_wready, s0_axi_bresp, s0_axi_bvalid,
           s0_axi_arready, s0_axi_rdata, s0_axi_rresp, s0_axi_rvalid
  );

  modport slave (
    input  s0_axi_awaddr, s0_axi_awvalid, s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid,
           s0_axi_bready, s0_axi_araddr, s0_axi_arvalid, s0_axi_rready,
    output s0_axi_awready, s0_axi_wready, s0_axi_bresp, s0_axi_bvalid,
           s0_axi_arready, s0_axi_rdata, s0_axi_rresp, s0_axi_rvalid
  );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register-bank responder with independent write and read FSMs.
// Define AXIL_REG_ERR_RESP_EN to answer misaligned/out-of-range accesses with SLVERR.
module axil_reg_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                 s0_axi_aclk,
  input  logic                 s0_axi_areset,
  axil_reg_responder_if.slave  s0_axi
);
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LSB       = $clog2(STRB_W);
  localparam int IDX_W     = ADDR_WIDTH - LSB;
  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef AXIL_REG_ERR_RESP_EN
  localparam logic ERR_RESP_EN = 1'b1;
`else
  localparam logic ERR_RESP_EN = 1'b0;
`endif

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] addr);
    logic [IDX_W-1:0] idx;
    idx = addr[ADDR_WIDTH-1:LSB];
    return (addr[LSB-1:0] == {LSB{1'b0}}) && (int'(idx) < NUM_REGS);
  endfunction

  function automatic logic [REG_IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
    return addr[LSB +: REG_IDX_W];
  endfunction

  function automatic logic resp_for(input logic [ADDR_WIDTH-1:0] addr);
    return ERR_RESP_EN & ~addr_valid(addr);
  endfunction

  wstate_e                 wstate_q, wstate_d;
  rstate_e                 rstate_q, rstate_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic                    bresp_q, bresp_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    aw_hs_s, w_hs_s, ar_hs_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [STRB_W-1:0]       wr_strb_s;
  logic [REG_IDX_W-1:0]    wr_idx_s;

  assign aw_hs_s   = s0_axi.s0_axi_awvalid & awready_q;
  assign w_hs_s    = s0_axi.s0_axi_wvalid & wready_q;
  assign ar_hs_s   = s0_axi.s0_axi_arvalid & arready_q;
  // A beat captured earlier wins over whatever is currently on the bus.
  assign wr_addr_s = aw_done_q ? awaddr_q : s0_axi.s0_axi_awaddr;
  assign wr_data_s = w_done_q ? wdata_q : s0_axi.s0_axi_wdata;
  assign wr_strb_s = w_done_q ? wstrb_q : s0_axi.s0_axi_wstrb;
  assign wr_idx_s  = addr_index(wr_addr_s);

  // State, capture and register-bank flops with synchronous reset.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Write channel: collect AW and W in any order, commit and respond once both are in.
  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          awaddr_d  = s0_axi.s0_axi_awaddr;
          aw_done_d = 1'b1;
          awready_d = 1'b0;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (w_hs_s) begin
          wdata_d  = s0_axi.s0_axi_wdata;
          wstrb_d  = s0_axi.s0_axi_wstrb;
          w_done_d = 1'b1;
          wready_d = 1'b0;
        end else begin
          w_done_d = w_done_q;
        end
        if ((aw_done_q | aw_hs_s) & (w_done_q | w_hs_s)) begin
          wstate_d  = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = resp_for(wr_addr_s);
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (addr_valid(wr_addr_s)) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_strb_s[b]) begin
                regs_d[wr_idx_s][8*b +: 8] = wr_data_s[8*b +: 8];
              end else begin
                regs_d[wr_idx_s][8*b +: 8] = regs_q[wr_idx_s][8*b +: 8];
              end
            end
          end else begin
            bvalid_d = 1'b1;
          end
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (s0_axi.s0_axi_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: begin
        wstate_d  = W_IDLE;
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  // Read channel: latch the addressed word on AR, hold it until R is accepted.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = resp_for(s0_axi.s0_axi_araddr);
          if (addr_valid(s0_axi.s0_axi_araddr)) begin
            rdata_d = regs_q[addr_index(s0_axi.s0_axi_araddr)];
          end else begin
            rdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s0_axi.s0_axi_rready) begin
          rstate_d  = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: begin
        rstate_d  = R_IDLE;
        rvalid_d  = 1'b0;
        arready_d = 1'b1;
      end
    endcase
  end

  assign s0_axi.s0_axi_awready = awready_q;
  assign s0_axi.s0_axi_wready  = wready_q;
  assign s0_axi.s0_axi_bvalid  = bvalid_q;
  assign s0_axi.s0_axi_bresp   = bresp_q;
  assign s0_axi.s0_axi_arready = arready_q;
  assign s0_axi.s0_axi_rvalid  = rvalid_q;
  assign s0_axi.s0_axi_rresp   = rresp_q;
  assign s0_axi.s0_axi_rdata   = rdata_q;
endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized self-checking bench for axil_reg_responder against an array-based register model.
// Honours AXIL_REG_ERR_RESP_EN so expected responses follow the build.
module tb_axil_reg_responder;
  logic clk;
  logic areset;
  int   n_checks;
  int   n_pass;
  logic [31:0] model [8];
`ifdef AXIL_REG_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  axil_reg_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  axil_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8)) dut (
    .s0_axi_aclk   (clk),
    .s0_axi_areset (areset),
    .s0_axi        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bit addr_ok(input int a);
    return (a % 4 == 0) && (a / 4 < 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_sent, w_sent, aw_fire, w_fire;
    bit exp_resp;
    int t;
    exp_resp = ERR_EN && !addr_ok(addr);
    aw_sent = 1'b0; w_sent = 1'b0; t = 0;
    while (!(aw_sent && w_sent) && t < 40) begin
      bus.s0_axi_awaddr  = addr[7:0];
      bus.s0_axi_wdata   = data;
      bus.s0_axi_wstrb   = strb;
      bus.s0_axi_awvalid = !aw_sent && (t >= aw_dly);
      bus.s0_axi_wvalid  = !w_sent && (t >= w_dly);
      aw_fire = bus.s0_axi_awvalid && bus.s0_axi_awready;
      w_fire  = bus.s0_axi_wvalid && bus.s0_axi_wready;
      tick();
      if (aw_fire) aw_sent = 1'b1;
      if (w_fire)  w_sent  = 1'b1;
      if (!(aw_sent && w_sent)) begin
        check_eq("bvalid_early", bus.s0_axi_bvalid, 1'b0);
        check_eq("awready_wait", bus.s0_axi_awready, !aw_sent);
        check_eq("wready_wait", bus.s0_axi_wready, !w_sent);
      end
      t++;
    end
    bus.s0_axi_awvalid = 1'b0;
    bus.s0_axi_wvalid  = 1'b0;
    check_eq("wr_handshake", aw_sent && w_sent, 1'b1);
    check_eq("bvalid", bus.s0_axi_bvalid, 1'b1);
    check_eq("bresp", bus.s0_axi_bresp, exp_resp);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check_eq("bvalid_hold", bus.s0_axi_bvalid, 1'b1);
      check_eq("bresp_hold", bus.s0_axi_bresp, exp_resp);
      check_eq("aw_w_ready_hold", {bus.s0_axi_awready, bus.s0_axi_wready}, 2'b00);
    end
    bus.s0_axi_bready = 1'b1;
    tick();
    bus.s0_axi_bready = 1'b0;
    check_eq("bvalid_clear", bus.s0_axi_bvalid, 1'b0);
    check_eq("aw_w_ready_back", {bus.s0_axi_awready, bus.s0_axi_wready}, 2'b11);
    if (addr_ok(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[addr/4][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic do_read(input int addr, input int ar_dly, input int r_dly,
                         output logic [31:0] rd);
    logic [31:0] exp_data;
    bit exp_resp, sent, fire;
    int t;
    if (addr_ok(addr)) exp_data = model[addr/4];
    else exp_data = 32'h0;
    exp_resp = ERR_EN && !addr_ok(addr);
    sent = 1'b0; t = 0;
    while (!sent && t < 40) begin
      bus.s0_axi_araddr  = addr[7:0];
      bus.s0_axi_arvalid = (t >= ar_dly);
      fire = bus.s0_axi_arvalid && bus.s0_axi_arready;
      tick();
      if (fire) sent = 1'b1;
      else check_eq("rvalid_early", bus.s0_axi_rvalid, 1'b0);
      t++;
    end
    bus.s0_axi_arvalid = 1'b0;
    check_eq("rd_handshake", sent, 1'b1);
    check_eq("rvalid", bus.s0_axi_rvalid, 1'b1);
    check_eq("rdata", bus.s0_axi_rdata, exp_data);
    check_eq("rresp", bus.s0_axi_rresp, exp_resp);
    check_eq("arready_busy", bus.s0_axi_arready, 1'b0);
    rd = bus.s0_axi_rdata;
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check_eq("rvalid_hold", bus.s0_axi_rvalid, 1'b1);
      check_eq("rdata_hold", bus.s0_axi_rdata, exp_data);
      check_eq("arready_hold", bus.s0_axi_arready, 1'b0);
    end
    bus.s0_axi_rready = 1'b1;
    tick();
    bus.s0_axi_rready = 1'b0;
    check_eq("rvalid_clear", bus.s0_axi_rvalid, 1'b0);
    check_eq("arready_back", bus.s0_axi_arready, 1'b1);
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
    else return int'($urandom_range(0, 7)) * 4;
  endfunction

  initial begin
    logic [31:0] rd, rd2;
    int a, a2;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    bus.s0_axi_awaddr = 8'h0; bus.s0_axi_awvalid = 1'b0;
    bus.s0_axi_wdata  = 32'h0; bus.s0_axi_wstrb = 4'h0; bus.s0_axi_wvalid = 1'b0;
    bus.s0_axi_bready = 1'b0;
    bus.s0_axi_araddr = 8'h0; bus.s0_axi_arvalid = 1'b0; bus.s0_axi_rready = 1'b0;
    areset = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    check_eq("rst_readies", {bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready}, 3'b111);
    check_eq("rst_valids", {bus.s0_axi_bvalid, bus.s0_axi_rvalid}, 2'b00);
    check_eq("rst_rdata", bus.s0_axi_rdata, 32'h0);

    // Basic write/readback with AW and W together.
    do_write(32'h04, 32'h0000_0017, 4'hF, 0, 0, 0);
    do_read(32'h04, 0, 0, rd);
    check_eq("t1_value", rd, 32'h0000_0017);
    // Partial strobe merge.
    do_write(32'h08, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
    do_write(32'h08, 32'h1122_3344, 4'h5, 0, 0, 0);
    do_read(32'h08, 1, 0, rd);
    check_eq("t2_merge", rd, 32'hAA22_CC44);
    // W leads AW by three cycles, then backpressure on both responses.
    do_write(32'h10, 32'h5A5A_0F0F, 4'hF, 3, 0, 0);
    do_write(32'h14, 32'h0BAD_F00D, 4'hF, 0, 2, 5);
    do_read(32'h14, 0, 5, rd);
    // Zero strobe on a valid address.
    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    do_read(32'h10, 0, 0, rd);
    check_eq("t_zero_strb", rd, 32'h5A5A_0F0F);
    // Invalid addresses leave every register alone.
    do_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_write(32'h05, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
    do_read(32'h40, 0, 0, rd);
    check_eq("t5_oob_rdata", rd, 32'h0);
    for (int i = 0; i < 8; i++) do_read(i * 4, 0, 0, rd);
    // Simultaneous read and write of one register returns the old value.
    do_write(32'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
    fork
      do_write(32'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
      do_read(32'h0C, 0, 0, rd);
    join
    check_eq("rw_same_old", rd, 32'h1234_5678);
    do_read(32'h0C, 0, 0, rd);
    check_eq("rw_same_new", rd, 32'hCAFE_F00D);

    for (int n = 0; n < 40; n++) begin
      a  = rand_addr();
      a2 = rand_addr();
      case ($urandom_range(0, 2))
        0: do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd);
        default: fork
          do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2));
          do_read(a2, $urandom_range(0, 2), $urandom_range(0, 2), rd2);
        join
      endcase
    end

    // Reset with both responses pending.
    bus.s0_axi_awaddr = 8'h18; bus.s0_axi_wdata = 32'h7777_7777; bus.s0_axi_wstrb = 4'hF;
    bus.s0_axi_awvalid = 1'b1; bus.s0_axi_wvalid = 1'b1;
    bus.s0_axi_araddr = 8'h08; bus.s0_axi_arvalid = 1'b1;
    tick();
    bus.s0_axi_awvalid = 1'b0; bus.s0_axi_wvalid = 1'b0; bus.s0_axi_arvalid = 1'b0;
    check_eq("pre_rst_valids", {bus.s0_axi_bvalid, bus.s0_axi_rvalid}, 2'b11);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_eq("mid_rst_valids", {bus.s0_axi_bvalid, bus.s0_axi_rvalid}, 2'b00);
    check_eq("mid_rst_readies", {bus.s0_axi_awready, bus.s0_axi_wready, bus.s0_axi_arready}, 3'b111);
    check_eq("mid_rst_resps", {bus.s0_axi_bresp, bus.s0_axi_rresp}, 2'b00);
    check_eq("mid_rst_rdata", bus.s0_axi_rdata, 32'h0);
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    for (int i = 0; i < 8; i++) do_read(i * 4, 0, 0, rd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
